// File: rtl/filt_pkt_pkg.sv
// ============================================================================
// filt_pkt_pkg : shared constants, FSM state type and CRC helper for the
//                filtered-sample frame packer.  Honors FRAME_CRC_EN.
// Revision     : 1.0
// ============================================================================
`default_nettype none

package filt_pkt_pkg;

  localparam logic [7:0] HDR_SYNC = 8'hA5;

`ifdef FRAME_CRC_EN
  localparam int FRAME_LEN = 7;
`else
  localparam int FRAME_LEN = 6;
`endif

  localparam int CH0_ADS1 = 0;
  localparam int CH1_ADS1 = 1;
  localparam int CH0_ADS2 = 2;
  localparam int CH1_ADS2 = 3;

  localparam logic [15:0] CRC_POLY = 16'h1021;
  localparam logic [15:0] CRC_INIT = 16'hFFFF;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_COLLECT = 2'd1,
    ST_COMMIT  = 2'd2
  } state_t;

  // CRC-16/CCITT over one 16-bit word, MSB first, no reflection
  function automatic logic [15:0] crc16_word(input logic [15:0] crc_in,
                                             input logic [15:0] data);
    logic [15:0] c;
    c = crc_in;
    for (int i = 15; i >= 0; i--) begin
      if (c[15] ^ data[i]) c = {c[14:0], 1'b0} ^ CRC_POLY;
      else                 c = {c[14:0], 1'b0};
    end
    return c;
  endfunction

endpackage

`default_nettype wire

// File: rtl/filt_frame_packer_if.sv
// ============================================================================
// filt_frame_packer_if : valid/ready word stream from the packer to upload.
// Revision             : 1.0
// ============================================================================
`default_nettype none

interface filt_frame_packer_if;
  logic [15:0] frame_data;
  logic        frame_valid;
  logic        frame_ready;
  logic        frame_sof;
  logic        frame_eof;

  modport master (output frame_data, frame_valid, frame_sof, frame_eof,
                  input  frame_ready);
  modport slave  (input  frame_data, frame_valid, frame_sof, frame_eof,
                  output frame_ready);
endinterface

`default_nettype wire

// File: rtl/pkt_fifo.sv
// ============================================================================
// pkt_fifo : synchronous first-word-fall-through FIFO with free-count output.
// Revision : 1.0
// ============================================================================
`default_nettype none

module pkt_fifo #(
  parameter int DEPTH = 32,
  parameter int WIDTH = 18
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       wr_en,
  input  logic [WIDTH-1:0]           wr_data,
  input  logic                       rd_en,
  output logic [WIDTH-1:0]           rd_data,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     free_cnt
);
  localparam int            AW     = $clog2(DEPTH);
  localparam logic [AW:0]   C_FULL = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [AW:0]      r_count;
  logic             w_do_wr;
  logic             w_do_rd;

  assign w_do_wr  = wr_en && (r_count != C_FULL);
  assign w_do_rd  = rd_en && (r_count != '0);
  assign rd_data  = r_mem[r_rd_ptr];
  assign empty    = (r_count == '0);
  assign free_cnt = C_FULL - r_count;

  always_ff @(posedge clk) begin
    if (w_do_wr) r_mem[r_wr_ptr] <= wr_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_wr) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_do_rd) r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_do_wr, w_do_rd})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end
endmodule

`default_nettype wire

// File: rtl/filt_frame_packer.sv
// ============================================================================
// filt_frame_packer : gathers four filtered ADS samples into sequence-numbered
//                     frames and streams them through a word FIFO.
//                     Optional CRC word: define FRAME_CRC_EN.
// Revision          : 1.0
// ============================================================================
`default_nettype none

module filt_frame_packer
  import filt_pkt_pkg::*;
#(
  parameter int FIFO_DEPTH = 32,
  parameter int TIMEOUT    = 1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] Ch0_Dataf_ads1,
  input  logic [15:0] Ch1_Dataf_ads1,
  input  logic [15:0] Ch0_Dataf_ads2,
  input  logic [15:0] Ch1_Dataf_ads2,
  input  logic        Ch0_Dataf_en_ads1,
  input  logic        Ch1_Dataf_en_ads1,
  input  logic        Ch0_Dataf_en_ads2,
  input  logic        Ch1_Dataf_en_ads2,
  input  logic        Ch0_Dataf_sign_ads1,
  input  logic        Ch1_Dataf_sign_ads1,
  input  logic        Ch0_Dataf_sign_ads2,
  input  logic        Ch1_Dataf_sign_ads2,
  filt_frame_packer_if.master frame_if,
  output logic [15:0] drop_cnt,
  output logic        dup_err
);
  localparam int            AW     = $clog2(FIFO_DEPTH);
  localparam int            TW     = $clog2(TIMEOUT);
  localparam logic [2:0]    C_LAST = 3'(FRAME_LEN - 1);
  localparam logic [AW:0]   C_FLEN = (AW+1)'(FRAME_LEN);

  logic [3:0]    w_stb;
  logic [3:0]    w_sgn_in;
  logic [15:0]   w_din [4];

  assign w_stb[CH0_ADS1]    = Ch0_Dataf_en_ads1;
  assign w_stb[CH1_ADS1]    = Ch1_Dataf_en_ads1;
  assign w_stb[CH0_ADS2]    = Ch0_Dataf_en_ads2;
  assign w_stb[CH1_ADS2]    = Ch1_Dataf_en_ads2;
  assign w_sgn_in[CH0_ADS1] = Ch0_Dataf_sign_ads1;
  assign w_sgn_in[CH1_ADS1] = Ch1_Dataf_sign_ads1;
  assign w_sgn_in[CH0_ADS2] = Ch0_Dataf_sign_ads2;
  assign w_sgn_in[CH1_ADS2] = Ch1_Dataf_sign_ads2;
  assign w_din[CH0_ADS1]    = Ch0_Dataf_ads1;
  assign w_din[CH1_ADS1]    = Ch1_Dataf_ads1;
  assign w_din[CH0_ADS2]    = Ch0_Dataf_ads2;
  assign w_din[CH1_ADS2]    = Ch1_Dataf_ads2;

  state_t        r_state;
  logic [3:0]    r_got;
  logic [3:0]    r_sgn;
  logic [15:0]   r_smp [4];
  logic [TW-1:0] r_tmo;
  logic [15:0]   r_seq;
  logic [15:0]   r_drop;
  logic          r_dup;
  logic          r_busy;
  logic [2:0]    r_idx;
  logic [15:0]   r_frame [6];
  logic [15:0]   w_word;
  logic          w_commit;
  logic          w_room;
  logic [AW:0]   w_free;
  logic [17:0]   w_rd_data;
  logic          w_empty;

  assign w_commit = (r_state == ST_COMMIT) && !r_busy;
  assign w_room   = (w_free >= C_FLEN);
  assign drop_cnt = r_drop;
  assign dup_err  = r_dup;

  // Capture set; strobes seen in the snapshot cycle start the next set
  always_ff @(posedge clk) begin
    if (rst) begin
      r_got <= '0;
      r_sgn <= '0;
      r_dup <= 1'b0;
      for (int i = 0; i < 4; i++) r_smp[i] <= '0;
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (w_stb[i]) begin
          r_smp[i] <= w_din[i];
          r_sgn[i] <= w_sgn_in[i];
        end else if (w_commit) begin
          r_smp[i] <= '0;
          r_sgn[i] <= 1'b0;
        end
      end
      r_got <= w_commit ? w_stb : (r_got | w_stb);
      if (|(w_stb & r_got) && !w_commit) r_dup <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_tmo   <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (|w_stb) begin
            r_tmo   <= TW'(1);
            r_state <= (w_stb == 4'hF) ? ST_COMMIT : ST_COLLECT;
          end
        end
        ST_COLLECT: begin
          r_tmo <= r_tmo + 1'b1;
          if (((r_got | w_stb) == 4'hF) || (r_tmo == TW'(TIMEOUT - 1)))
            r_state <= ST_COMMIT;
        end
        ST_COMMIT: begin
          if (w_commit) begin
            r_tmo   <= (|w_stb) ? TW'(1) : '0;
            r_state <= (|w_stb) ? ST_COLLECT : ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // Writer: sequence number advances on every commit, kept or dropped
  always_ff @(posedge clk) begin
    if (rst) begin
      r_seq  <= '0;
      r_drop <= '0;
      r_busy <= 1'b0;
      r_idx  <= '0;
    end else if (w_commit) begin
      r_seq <= r_seq + 1'b1;
      if (w_room) begin
        r_busy <= 1'b1;
        r_idx  <= '0;
      end else if (r_drop != 16'hFFFF) begin
        r_drop <= r_drop + 1'b1;
      end
    end else if (r_busy) begin
      r_idx <= r_idx + 3'd1;
      if (r_idx == C_LAST) r_busy <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (w_commit) begin
      r_frame[0] <= {HDR_SYNC, r_got, r_sgn};
      r_frame[1] <= r_seq;
      for (int i = 0; i < 4; i++) r_frame[i+2] <= r_smp[i];
    end
  end

`ifdef FRAME_CRC_EN
  logic [15:0] r_crc;

  always_ff @(posedge clk) begin
    if (rst)                            r_crc <= CRC_INIT;
    else if (w_commit)                  r_crc <= CRC_INIT;
    else if (r_busy && r_idx < 3'd6)    r_crc <= crc16_word(r_crc, w_word);
  end

  always_comb begin
    w_word = r_crc;
    if (r_idx < 3'd6) w_word = r_frame[r_idx];
  end
`else
  always_comb begin
    w_word = '0;
    if (r_idx < 3'd6) w_word = r_frame[r_idx];
  end
`endif

  pkt_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (18)
  ) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .wr_en    (r_busy),
    .wr_data  ({(r_idx == 3'd0), (r_idx == C_LAST), w_word}),
    .rd_en    (frame_if.frame_ready),
    .rd_data  (w_rd_data),
    .empty    (w_empty),
    .free_cnt (w_free)
  );

  assign frame_if.frame_valid = !w_empty;
  assign frame_if.frame_data  = w_empty ? 16'h0000 : w_rd_data[15:0];
  assign frame_if.frame_sof   = !w_empty && w_rd_data[17];
  assign frame_if.frame_eof   = !w_empty && w_rd_data[16];
endmodule

`default_nettype wire

// File: tb/tb_filt_frame_packer.sv
// ============================================================================
// tb_filt_frame_packer : directed self-checking bench for filt_frame_packer.
// Revision             : 1.0
// ============================================================================
`default_nettype none

module tb_filt_frame_packer;
  localparam int TMO   = 16;
  localparam int DEPTH = 32;
`ifdef FRAME_CRC_EN
  localparam int FLEN = 7;
`else
  localparam int FLEN = 6;
`endif

  typedef logic [15:0] frame_t [7];

  typedef struct packed {
    logic [3:0]  en;
    logic [3:0]  sg;
    logic [63:0] din;   // {ch3, ch2, ch1, ch0}
    logic [95:0] ex;    // {w0, w1, w2, w3, w4, w5}
    logic [7:0]  lat;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] d [4];
  logic [3:0]  en = '0;
  logic [3:0]  sg = '0;
  logic [15:0] drop_cnt;
  logic        dup_err;
  int          total = 0;
  int          bad   = 0;

  always #5 clk = ~clk;

  filt_frame_packer_if fif();

  filt_frame_packer #(
    .FIFO_DEPTH (DEPTH),
    .TIMEOUT    (TMO)
  ) dut (
    .clk                 (clk),
    .rst                 (rst),
    .Ch0_Dataf_ads1      (d[0]),
    .Ch1_Dataf_ads1      (d[1]),
    .Ch0_Dataf_ads2      (d[2]),
    .Ch1_Dataf_ads2      (d[3]),
    .Ch0_Dataf_en_ads1   (en[0]),
    .Ch1_Dataf_en_ads1   (en[1]),
    .Ch0_Dataf_en_ads2   (en[2]),
    .Ch1_Dataf_en_ads2   (en[3]),
    .Ch0_Dataf_sign_ads1 (sg[0]),
    .Ch1_Dataf_sign_ads1 (sg[1]),
    .Ch0_Dataf_sign_ads2 (sg[2]),
    .Ch1_Dataf_sign_ads2 (sg[3]),
    .frame_if            (fif),
    .drop_cnt            (drop_cnt),
    .dup_err             (dup_err)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  function automatic frame_t mk(input logic [15:0] w0, w1, w2, w3, w4, w5);
    frame_t f;
    logic [15:0] c;
    logic fb;
    f[0] = w0; f[1] = w1; f[2] = w2; f[3] = w3; f[4] = w4; f[5] = w5;
    c = 16'hFFFF;
    for (int w = 0; w < 6; w++)
      for (int b = 15; b >= 0; b--) begin
        fb = c[15] ^ f[w][b];
        c  = {c[14:0], 1'b0};
        if (fb) c = c ^ 16'h1021;
      end
    f[6] = c;
    return f;
  endfunction

  task automatic strobe(input logic [3:0] e, input logic [3:0] s,
                        input logic [15:0] d0, d1, d2, d3);
    en = e; sg = s;
    d[0] = d0; d[1] = d1; d[2] = d2; d[3] = d3;
    tick;
    en = '0; sg = '0;
  endtask

  task automatic read_frame(input string tag, input frame_t w, input int budget);
    int n;
    n = 0;
    fif.frame_ready = 1'b1;
    while (!fif.frame_valid && n < budget) begin
      tick;
      n++;
    end
    for (int i = 0; i < FLEN; i++) begin
      chk($sformatf("%s word%0d {valid,sof,eof,data}", tag, i),
          {13'd0, fif.frame_valid, fif.frame_sof, fif.frame_eof, fif.frame_data},
          {13'd0, 1'b1, (i == 0), (i == FLEN - 1), w[i]});
      tick;
    end
  endtask

  vec_t vt [5];

  initial begin
    int n;
    int nbuf;
    frame_t f;

    vt[0] = '{4'hF, 4'hA, {16'h4444, 16'h3333, 16'h2222, 16'h1111},
              {16'hA5FA, 16'h0000, 16'h1111, 16'h2222, 16'h3333, 16'h4444}, 8'd2};
    vt[1] = '{4'h5, 4'h5, {16'h0000, 16'hCCCC, 16'h0000, 16'hAAAA},
              {16'hA555, 16'h0001, 16'hAAAA, 16'h0000, 16'hCCCC, 16'h0000}, 8'(TMO + 1)};
    vt[2] = '{4'hF, 4'h0, {16'hFFFF, 16'h0001, 16'h7FFF, 16'h8000},
              {16'hA5F0, 16'h0002, 16'h8000, 16'h7FFF, 16'h0001, 16'hFFFF}, 8'd2};
    vt[3] = '{4'h8, 4'h8, {16'hBEEF, 16'h0000, 16'h0000, 16'h0000},
              {16'hA588, 16'h0003, 16'h0000, 16'h0000, 16'h0000, 16'hBEEF}, 8'(TMO + 1)};
    vt[4] = '{4'h2, 4'hF, {16'h5555, 16'h6666, 16'h1234, 16'h7777},
              {16'hA522, 16'h0004, 16'h0000, 16'h1234, 16'h0000, 16'h0000}, 8'(TMO + 1)};

    for (int i = 0; i < 4; i++) d[i] = '0;
    fif.frame_ready = 1'b0;
    rst = 1'b1;
    repeat (3) tick;
    chk("reset valid/sof/eof", {29'd0, fif.frame_valid, fif.frame_sof, fif.frame_eof}, 32'd0);
    chk("reset data", {16'd0, fif.frame_data}, 32'd0);
    rst = 1'b0;
    tick;
    chk("idle drop_cnt", {16'd0, drop_cnt}, 32'd0);
    chk("idle dup_err", {31'd0, dup_err}, 32'd0);
    chk("idle valid", {31'd0, fif.frame_valid}, 32'd0);

    // table: full sets and timeout-flushed partial sets
    for (int k = 0; k < 5; k++) begin
      strobe(vt[k].en, vt[k].sg, vt[k].din[15:0], vt[k].din[31:16],
             vt[k].din[47:32], vt[k].din[63:48]);
      fif.frame_ready = 1'b1;
      n = 0;
      while (!fif.frame_valid && n < TMO + 8) begin
        tick;
        n++;
      end
      chk($sformatf("vec%0d latency", k), n, {24'd0, vt[k].lat});
      f = mk(vt[k].ex[95:80], vt[k].ex[79:64], vt[k].ex[63:48],
             vt[k].ex[47:32], vt[k].ex[31:16], vt[k].ex[15:0]);
      read_frame($sformatf("vec%0d", k), f, 0);
      repeat (2) tick;
    end
    chk("no dup after table", {31'd0, dup_err}, 32'd0);

    // duplicate strobe on channel 1 overwrites the sample
    strobe(4'h2, 4'h0, 16'h0, 16'h1111, 16'h0, 16'h0);
    tick;
    chk("dup before 2nd strobe", {31'd0, dup_err}, 32'd0);
    strobe(4'h2, 4'h0, 16'h0, 16'h9999, 16'h0, 16'h0);
    chk("dup after 2nd strobe", {31'd0, dup_err}, 32'd1);
    strobe(4'hD, 4'h0, 16'h0A0A, 16'h0, 16'h0C0C, 16'h0D0D);
    read_frame("dup", mk(16'hA5F0, 16'h0005, 16'h0A0A, 16'h9999, 16'h0C0C, 16'h0D0D), 20);
    repeat (2) tick;

    // back-pressure: 7 full sets with ready low
    fif.frame_ready = 1'b0;
    for (int k = 0; k < 7; k++) begin
      strobe(4'hF, 4'h0, 16'((k << 8) | 0), 16'((k << 8) | 1),
             16'((k << 8) | 2), 16'((k << 8) | 3));
      repeat (9) tick;
    end
    nbuf = DEPTH / FLEN;
    chk("bp drop_cnt", {16'd0, drop_cnt}, 32'(7 - nbuf));
    for (int k = 0; k < nbuf; k++) begin
      read_frame($sformatf("bp%0d", k),
                 mk(16'hA5F0, 16'(6 + k), 16'((k << 8) | 0), 16'((k << 8) | 1),
                    16'((k << 8) | 2), 16'((k << 8) | 3)), 4);
    end
    chk("bp drained", {31'd0, fif.frame_valid}, 32'd0);
    strobe(4'hF, 4'h0, 16'h0101, 16'h0202, 16'h0303, 16'h0404);
    read_frame("bp gap", mk(16'hA5F0, 16'd13, 16'h0101, 16'h0202, 16'h0303, 16'h0404), 20);
    repeat (2) tick;

    // reset while the writer is at word3
    fif.frame_ready = 1'b1;
    strobe(4'hF, 4'h0, 16'h1, 16'h2, 16'h3, 16'h4);
    repeat (4) tick;
    rst = 1'b1;
    tick;
    chk("mid-rst valid/sof/eof", {29'd0, fif.frame_valid, fif.frame_sof, fif.frame_eof}, 32'd0);
    chk("mid-rst data", {16'd0, fif.frame_data}, 32'd0);
    chk("mid-rst drop_cnt", {16'd0, drop_cnt}, 32'd0);
    chk("mid-rst dup_err", {31'd0, dup_err}, 32'd0);
    rst = 1'b0;
    repeat (8) tick;
    chk("post-rst fifo empty", {31'd0, fif.frame_valid}, 32'd0);
    strobe(4'hF, 4'h0, 16'hDEAD, 16'hBEEF, 16'hCAFE, 16'hF00D);
    read_frame("post-rst", mk(16'hA5F0, 16'h0000, 16'hDEAD, 16'hBEEF, 16'hCAFE, 16'hF00D), 20);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

`default_nettype wire
